// File: rtl/microstep_sequencer_pkg.sv
// Shared definitions for the SAP-1 microstep sequencer and the decoder it feeds.
// Both sides take the step count from here, so their instruction-slot lengths cannot diverge.
package microstep_sequencer_pkg;

    localparam int DEFAULT_INSTRUCTION_STEPS = 8;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        PAUSE    = 2'd1,
        STEP_ONE = 2'd2,
        HALTED   = 2'd3
    } seq_state_t;

    function automatic logic is_tick_state(input seq_state_t s);
        return (s == RUN) || (s == STEP_ONE);
    endfunction

endpackage

// File: rtl/microstep_sequencer_rise_edge_detect.sv
// Single-flop rising-edge detector for debounced front-panel button levels.
// Produces a one-cycle pulse on the cycle the level first reads high.
module rise_edge_detect (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_level,
    output logic o_pulse
);

    logic level_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= i_level;
        end
    end

    assign o_pulse = i_level & ~level_q;

endmodule

// File: rtl/microstep_sequencer.sv
// SAP-1 microstep sequencer: step index, run/pause/single-step/halt control,
// datapath clock enable and retired-instruction counter.
module microstep_sequencer
    import microstep_sequencer_pkg::*;
#(
    parameter  int INSTRUCTION_STEPS = DEFAULT_INSTRUCTION_STEPS,
    parameter  int COUNT_WIDTH       = 16,
    localparam int STEP_WIDTH        = $clog2(INSTRUCTION_STEPS)
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_halt,
    input  logic                   i_adv,
    input  logic                   i_single_step,
    input  logic                   i_step_req,
    input  logic                   i_restart,
    output logic [STEP_WIDTH-1:0]  o_step,
    output logic                   o_clk_en,
    output logic                   o_halted,
    output logic                   o_paused,
    output logic                   o_overrun,
    output logic [COUNT_WIDTH-1:0] o_instr_count
);

    localparam logic [STEP_WIDTH-1:0] LAST_STEP = STEP_WIDTH'(INSTRUCTION_STEPS - 1);

    seq_state_t             state, state_next;
    logic [STEP_WIDTH-1:0]  step, step_next;
    logic [COUNT_WIDTH-1:0] count, count_next;
    logic                   overrun, overrun_next;
    logic                   step_pulse;
    logic                   tick;

    rise_edge_detect u_step_edge (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_level (i_step_req),
        .o_pulse (step_pulse)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state   <= RUN;
            step    <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= state_next;
            step    <= step_next;
            count   <= count_next;
            overrun <= overrun_next;
        end
    end

    // Reset leaves state at RUN, so the enable is masked by reset itself.
    assign tick = is_tick_state(state) & ~i_reset;

    always_comb begin
        state_next   = state;
        step_next    = step;
        count_next   = count;
        overrun_next = overrun;

        if (i_restart) begin
            step_next    = '0;
            overrun_next = 1'b0;
            state_next   = i_single_step ? PAUSE : RUN;
        end else if (is_tick_state(state)) begin
            if (i_halt) begin
                state_next = HALTED;
            end else begin
                if (i_adv) begin
                    step_next  = '0;
                    count_next = count + COUNT_WIDTH'(1);
                end else if (step == LAST_STEP) begin
                    step_next    = '0;
                    count_next   = count + COUNT_WIDTH'(1);
                    overrun_next = 1'b1;
                end else begin
                    step_next = step + STEP_WIDTH'(1);
                end

                if (state == STEP_ONE || i_single_step) begin
                    state_next = PAUSE;
                end else begin
                    state_next = RUN;
                end
            end
        end else if (state == PAUSE) begin
            if (!i_single_step) begin
                state_next = RUN;
            end else if (step_pulse) begin
                state_next = STEP_ONE;
            end
        end
    end

    assign o_step        = step;
    assign o_clk_en      = tick;
    assign o_halted      = (state == HALTED);
    assign o_paused      = (state == PAUSE);
    assign o_overrun     = overrun;
    assign o_instr_count = count;

endmodule

// File: tb/tb_microstep_sequencer.sv
// Scoreboard bench for microstep_sequencer: a behavioural model pushes the expected
// post-edge outputs each cycle; they are popped and compared one cycle later.
module tb_microstep_sequencer;

    localparam int STEPS = 8;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          halt, adv, ss, req, restart;
    logic [2:0]    step;
    logic          clk_en, halted, paused, overrun;
    logic [CW-1:0] icount;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]    step;
        logic [CW-1:0] count;
        logic          ovr;
        logic          clk_en;
        logic          halted;
        logic          paused;
    } exp_t;

    exp_t sb[$];

    // model state: 0 RUN, 1 PAUSE, 2 STEP_ONE, 3 HALTED
    int            m_st;
    logic [2:0]    m_step;
    logic [CW-1:0] m_cnt;
    logic          m_ovr;
    logic          m_prev;

    microstep_sequencer #(
        .INSTRUCTION_STEPS (STEPS),
        .COUNT_WIDTH       (CW)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_halt        (halt),
        .i_adv         (adv),
        .i_single_step (ss),
        .i_step_req    (req),
        .i_restart     (restart),
        .o_step        (step),
        .o_clk_en      (clk_en),
        .o_halted      (halted),
        .o_paused      (paused),
        .o_overrun     (overrun),
        .o_instr_count (icount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_step = '0; m_cnt = '0; m_ovr = 1'b0; m_prev = 1'b0;
    endtask

    task automatic model_step();
        logic pulse;
        pulse = req & ~m_prev;
        if (restart) begin
            m_step = '0;
            m_ovr  = 1'b0;
            m_st   = ss ? 1 : 0;
        end else if (m_st == 0 || m_st == 2) begin
            if (halt) begin
                m_st = 3;
            end else begin
                if (adv) begin
                    m_step = '0; m_cnt = m_cnt + 1'b1;
                end else if (m_step == 3'd7) begin
                    m_step = '0; m_cnt = m_cnt + 1'b1; m_ovr = 1'b1;
                end else begin
                    m_step = m_step + 1'b1;
                end
                m_st = (m_st == 2 || ss) ? 1 : 0;
            end
        end else if (m_st == 1) begin
            if (!ss) m_st = 0;
            else if (pulse) m_st = 2;
        end
        m_prev = req;
    endtask

    task automatic cycle();
        exp_t e;
        model_step();
        e.step   = m_step;
        e.count  = m_cnt;
        e.ovr    = m_ovr;
        e.clk_en = (m_st == 0 || m_st == 2);
        e.halted = (m_st == 3);
        e.paused = (m_st == 1);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("step",    32'(step),    32'(e.step));
        check("count",   32'(icount),  32'(e.count));
        check("overrun", 32'(overrun), 32'(e.ovr));
        check("clk_en",  32'(clk_en),  32'(e.clk_en));
        check("halted",  32'(halted),  32'(e.halted));
        check("paused",  32'(paused),  32'(e.paused));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_step"},    32'(step),    0);
        check({tag, "_count"},   32'(icount),  0);
        check({tag, "_overrun"}, 32'(overrun), 0);
        check({tag, "_clk_en"},  32'(clk_en),  0);
        check({tag, "_halted"},  32'(halted),  0);
        check({tag, "_paused"},  32'(paused),  0);
    endtask

    // Asserts reset between clock edges and checks outputs before any edge arrives.
    task automatic do_reset(input string tag);
        #2 rst = 1'b1;
        #1 check_reset_outputs(tag);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    int ticks;

    initial begin
        rst = 1'b1; halt = 0; adv = 0; ss = 0; req = 0; restart = 0;
        #1 check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();

        // free run, adv at step 4
        for (int i = 0; i < 6; i++) begin
            adv = (m_step == 3'd4);
            cycle();
        end
        adv = 0;
        check("t1_count", 32'(icount), 1);
        check("t1_step", 32'(step), 1);

        // slot exhaustion: 7 more ticks to step 0 with overrun, then step 2
        for (int i = 0; i < 9; i++) cycle();
        check("t2_overrun", 32'(overrun), 1);
        check("t2_count", 32'(icount), 2);
        check("t2_step", 32'(step), 2);

        // halt + adv together at step 2
        halt = 1; adv = 1;
        cycle();
        halt = 0; adv = 0;
        check("t4_halted", 32'(halted), 1);
        check("t4_step", 32'(step), 2);
        check("t4_count", 32'(icount), 2);
        check("t4_clk_en", 32'(clk_en), 0);
        req = 1; cycle(); req = 0; cycle();
        check("t4_step_req_ignored", 32'(step), 2);
        restart = 1; cycle(); restart = 0;
        check("t4_restart_step", 32'(step), 0);
        check("t4_restart_ovr", 32'(overrun), 0);
        check("t4_restart_count", 32'(icount), 2);
        cycle();

        // single-step
        do_reset("rst3");
        ss = 1; cycle(); cycle();
        check("t3_paused", 32'(paused), 1);
        check("t3_step0", 32'(step), 1);
        ticks = 0;
        for (int p = 0; p < 3; p++) begin
            req = 1; cycle(); ticks += int'(clk_en);
            req = 0; cycle(); ticks += int'(clk_en);
            cycle(); ticks += int'(clk_en);
        end
        check("t3_ticks", 32'(ticks), 3);
        check("t3_step", 32'(step), 4);
        ticks = 0;
        req = 1;
        for (int i = 0; i < 4; i++) begin cycle(); ticks += int'(clk_en); end
        req = 0; cycle(); ticks += int'(clk_en);
        check("t3_held_ticks", 32'(ticks), 1);
        check("t3_held_step", 32'(step), 5);

        // async reset from a busy PAUSE state
        ss = 0; cycle();
        adv = 1;
        for (int i = 0; i < 9; i++) cycle();
        adv = 0;
        for (int i = 0; i < 5; i++) begin
            ss = (i == 4);
            cycle();
        end
        cycle();
        check("t5_pre_paused", 32'(paused), 1);
        check("t5_pre_step", 32'(step), 5);
        check("t5_pre_count", 32'(icount), 9);
        do_reset("rst5");
        ss = 0; cycle();
        check("t5_first_tick", 32'(step), 1);

        // count wrap at 4 bits
        do_reset("rst6");
        adv = 1;
        for (int i = 0; i < 15; i++) cycle();
        check("t6_count15", 32'(icount), 15);
        cycle();
        adv = 0;
        check("t6_wrap", 32'(icount), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
